// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, the NOP encoding and the fetch FSM state type.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 4;

    // Opcode lives in the top nibble of every instruction word.
    localparam int unsigned OPC_MSB = INSTR_W - 1;
    localparam int unsigned OPC_LSB = INSTR_W - OPC_W;

    localparam logic [OPC_W-1:0]   OPC_NOP   = 4'b0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,
        F_WAIT = 2'd1,
        F_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid buffer holding an instruction word and its PC while IF/ID is stalled.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   load                capture load_instr/load_pc and mark the entry valid
//   clear               empty the entry (wins over load)
//   load_instr/load_pc  word and PC to capture
//   valid/instr/pc      current entry contents
module fetch_hold_buf
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q,    pc_d;

    // Next-entry selection; clear has priority over load.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end
    end

    // Entry registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory over a req/ready + valid
// handshake (one request outstanding), and loads the IF/ID register consumed by the decoder.
// Stalls hold IF/ID (an arriving word parks in a hold buffer); redirects reload the PC,
// insert a NOP into IF/ID and drop any in-flight wrong-path response.
// Optional build macro: FETCH_PERF_CNT_EN adds perf_fetched / perf_squashed counters.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   imem_req/imem_ready/imem_addr      read request channel (req held until ready)
//   imem_valid/imem_rdata              read response, one pulse per accepted request
//   stall                              IF/ID must hold this cycle
//   redirect/redirect_pc               restart fetch at redirect_pc, squash younger work
//   IFIDInstruction/IFIDPC/IFIDValid   IF/ID register outputs
//   perf_fetched/perf_squashed         (FETCH_PERF_CNT_EN only) event counters
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    input  logic               imem_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [INSTR_W-1:0] IFIDInstruction,
    output logic [ADDR_W-1:0]  IFIDPC,
    output logic               IFIDValid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_squashed
`endif
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               drop_q, drop_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
    logic               ifid_valid_q, ifid_valid_d;

    logic               hb_load, hb_clear, hb_valid;
    logic [INSTR_W-1:0] hb_instr;
    logic [ADDR_W-1:0]  hb_pc;

    logic               deliver;
    logic [INSTR_W-1:0] deliver_instr;
    logic [ADDR_W-1:0]  deliver_pc;
    logic [ADDR_W-1:0]  word_pc;

    // PC was bumped when the request was accepted, so the returning word belongs to PC-1.
    // A redirect between issue and return always sets the drop flag, so this never
    // has to name a redirected PC.
    assign word_pc = ADDR_W'(pc_q - 1'b1);

    fetch_hold_buf #(
        .ADDR_W (ADDR_W)
    ) u_hold_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (hb_load),
        .clear      (hb_clear),
        .load_instr (imem_rdata),
        .load_pc    (word_pc),
        .valid      (hb_valid),
        .instr      (hb_instr),
        .pc         (hb_pc)
    );

    // Next-state, PC, drop flag and IF/ID selection. Redirect outranks stall and delivery.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_valid_d  = ifid_valid_q;
        hb_load       = 1'b0;
        hb_clear      = 1'b0;
        deliver       = 1'b0;
        deliver_instr = NOP_INSTR;
        deliver_pc    = ifid_pc_q;

        if (redirect) begin
            pc_d         = redirect_pc;
            hb_clear     = 1'b1;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            unique case (state_q)
                F_REQ: begin
                    // Request accepted this cycle is already in flight: mark it for dropping.
                    if (imem_ready) begin
                        state_d = F_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                F_WAIT: begin
                    if (imem_valid) begin
                        state_d = F_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                F_HOLD:  state_d = F_REQ;
                default: state_d = F_REQ;
            endcase
        end else begin
            unique case (state_q)
                F_REQ: begin
                    if (imem_ready) begin
                        pc_d    = ADDR_W'(pc_q + 1'b1);
                        state_d = F_WAIT;
                    end
                end
                F_WAIT: begin
                    if (imem_valid) begin
                        drop_d = 1'b0;
                        if (drop_q) begin
                            state_d = F_REQ;
                        end else if (stall) begin
                            hb_load = 1'b1;
                            state_d = F_HOLD;
                        end else begin
                            deliver       = 1'b1;
                            deliver_instr = imem_rdata;
                            deliver_pc    = word_pc;
                            state_d       = F_REQ;
                        end
                    end
                end
                F_HOLD: begin
                    if (!stall) begin
                        hb_clear = 1'b1;
                        state_d  = F_REQ;
                        if (hb_valid) begin
                            deliver       = 1'b1;
                            deliver_instr = hb_instr;
                            deliver_pc    = hb_pc;
                        end
                    end
                end
                default: state_d = F_REQ;
            endcase

            // Unstalled IF/ID takes the delivered word or a bubble; PC stays with the last real word.
            if (!stall) begin
                ifid_instr_d = deliver_instr;
                ifid_pc_d    = deliver_pc;
                ifid_valid_d = deliver;
            end
        end
    end

    // Fetch state, PC, drop flag and IF/ID registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= F_REQ;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // Request is a decode of the state register, suppressed while reset is asserted.
    assign imem_req        = rst_n && (state_q == F_REQ);
    assign imem_addr       = pc_q;
    assign IFIDInstruction = ifid_instr_q;
    assign IFIDPC          = ifid_pc_q;
    assign IFIDValid       = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q,  perf_fetched_d;
    logic [31:0] perf_squashed_q, perf_squashed_d;
    logic        squash;

    // A squash is a response dropped by the flag or in a redirect cycle, or a flushed hold entry.
    always_comb begin
        squash          = ((state_q == F_WAIT) && imem_valid && (drop_q || redirect))
                          || (redirect && hb_valid);
        perf_fetched_d  = perf_fetched_q  + 32'(deliver);
        perf_squashed_d = perf_squashed_q + 32'(squash);
    end

    // Counter registers, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`endif

endmodule
